ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath width of the ALU result and the store data.
REQ-002 Parameter RADDR_W, default 3, destination register address width.
REQ-003 clk  in  1  single clock, all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 ex_valid  in  1  the execute stage presents a valid instruction.
REQ-006 stall  in  1  hold all stage state.
REQ-007 flush  in  1  kill the instruction being captured.
REQ-008 alu_out  in  DATA_W  ALU result.
REQ-009 alu_ccr  in  3  ALU flags: bit0 Z, bit1 N, bit2 C.
REQ-010 ccr_we  in  3  per-flag update mask, same bit order as alu_ccr.
REQ-011 setc, clrc  in  1 each  force C to 1 or 0.
REQ-012 ex_rd  in  RADDR_W; ex_wb_en, ex_mem_rd, ex_mem_wr  in  1 each; ex_store_data  in  DATA_W  control and data carried forward.
REQ-013 int_save, int_restore  in  1 each  CCR save/restore strobes (CCR_SAVE_EN only).
REQ-014 mem_valid  out  1; mem_alu_out  out  DATA_W; mem_rd  out  RADDR_W; mem_wb_en, mem_mem_rd, mem_mem_wr  out  1 each; mem_store_data  out  DATA_W  registered stage outputs.
REQ-015 ccr  out  3  architectural condition-code register.
REQ-016 fwd_valid  out  1  = mem_valid & mem_wb_en; fwd_data  out  DATA_W  = mem_alu_out (combinational from registers).

Function
REQ-017 Latency: one cycle from capture at the ex_* inputs to the mem_* outputs.
REQ-018 Control priority each edge: rst > flush > stall > normal capture.
REQ-019 Normal (no stall, no flush): every mem_* register loads its ex_* counterpart, mem_valid loads ex_valid.
REQ-020 Stall without flush: all mem_* outputs and ccr hold their values.
REQ-021 Flush (stall is ignored): mem_valid, mem_wb_en, mem_mem_rd and mem_mem_wr go to 0; mem data fields hold; ccr is not updated.
REQ-022 CCR update is qualified by upd = ex_valid & ~stall & ~flush; for each bit i with upd & ccr_we[i], ccr[i] loads alu_ccr[i]; other bits hold.
REQ-023 When upd is high, clrc forces ccr[2]=0 and otherwise setc forces ccr[2]=1, overriding ccr_we[2]; with setc and clrc both high, clrc wins.
REQ-024 An invalid instruction (ex_valid=0) never changes ccr and propagates as mem_valid=0.
REQ-025 Flag values are taken as given from the ALU; the stage performs no arithmetic on them.

Reset
REQ-026 While rst is high at an edge: every mem_* output goes to 0, ccr goes to 3'b000, and the saved CCR goes to 3'b000.
REQ-027 A rst asserted during a stall or flush overrides it in the same cycle; the first capture occurs on the first edge with rst low.

Configuration
REQ-028 With CCR_SAVE_EN defined, the block holds a 3-bit saved_ccr register.
REQ-029 With CCR_SAVE_EN, int_save copies the current ccr into saved_ccr, and int_restore loads ccr from saved_ccr with priority over REQ-022 and REQ-023.
REQ-030 With CCR_SAVE_EN, int_save and int_restore act regardless of stall; when both are high, restore wins and saved_ccr holds.
REQ-031 With CCR_SAVE_EN, flush suppresses int_save and int_restore in the same cycle.
REQ-032 Without CCR_SAVE_EN: no saved_ccr register, the int_save and int_restore ports remain present but are ignored.

Structure
REQ-033 Shared package riscp_pkg provides the DATA_W and RADDR_W defaults, CCR index constants Z_IDX=0, N_IDX=1, C_IDX=2, and a 3-bit typedef ccr_t.
REQ-034 The CCR logic (REQ-022, REQ-023, REQ-028 to REQ-032) is one sub-module, ccr_reg; the pipeline register stays in ex_mem_stage.

Verification
REQ-035 Reset: rst high for 2 cycles with random inputs -> all outputs 0, ccr=000.
REQ-036 Pass-through: alu_out=16'h1234, ex_rd=3'd5, ex_wb_en=1, ex_valid=1 -> next cycle mem_alu_out=16'h1234, mem_rd=5, fwd_valid=1, fwd_data=16'h1234.
REQ-037 Masked flags: ccr=000, alu_ccr=111, ccr_we=001 -> ccr=001; then setc=1, clrc=1, ccr_we=100 -> ccr[2]=0.
REQ-038 Stall/flush: stall=1 with a new alu_out=16'hBEEF -> outputs hold; stall=1 and flush=1 together -> mem_valid=0, control bits 0, ccr unchanged.
REQ-039 Invalid instruction: ex_valid=0, ccr_we=111, alu_ccr=111 -> ccr unchanged, mem_valid=0.
REQ-040 CCR_SAVE_EN: ccr=101, int_save -> saved_ccr=101; then an ALU writes ccr=010; then int_restore together with an ALU update -> ccr=101; repeat without the macro -> ccr follows the ALU only.

Source files
------------

// File: rtl/riscp_pkg.sv
// Shared definitions for the RISC pipeline: datapath defaults, condition-code
// register layout and its type.
package riscp_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_RADDR_W = 3;

    // Condition-code bit positions
    localparam int unsigned Z_IDX = 0;
    localparam int unsigned N_IDX = 1;
    localparam int unsigned C_IDX = 2;

    localparam int unsigned CCR_W = 3;

    typedef logic [CCR_W-1:0] ccr_t;

endpackage

// File: rtl/ex_mem_stage_ccr_reg.sv
// Architectural condition-code register with per-flag write mask and forced
// carry set/clear. With CCR_SAVE_EN defined, a shadow copy supports interrupt
// save/restore.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid, stall, flush    qualify the ALU update
//   alu_ccr, ccr_we           ALU flags and per-flag update mask
//   setc, clrc                force carry to 1 / 0 (clrc wins)
//   int_save, int_restore     shadow save/restore strobes (CCR_SAVE_EN only)
//   ccr                       current condition codes
// Macro: CCR_SAVE_EN enables the saved_ccr shadow register.
module ccr_reg
    import riscp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ex_valid,
    input  logic stall,
    input  logic flush,
    input  ccr_t alu_ccr,
    input  ccr_t ccr_we,
    input  logic setc,
    input  logic clrc,
    input  logic int_save,
    input  logic int_restore,
    output ccr_t ccr
);

    logic upd;
    ccr_t ccr_alu_next;

    assign upd = ex_valid & ~stall & ~flush;

    // Masked ALU update with carry override
    always_comb begin
        ccr_alu_next = ccr;
        for (int i = 0; i < int'(CCR_W); i++) begin
            if (upd && ccr_we[i]) begin
                ccr_alu_next[i] = alu_ccr[i];
            end
        end
        if (upd) begin
            if (clrc) begin
                ccr_alu_next[C_IDX] = 1'b0;
            end else if (setc) begin
                ccr_alu_next[C_IDX] = 1'b1;
            end
        end
    end

`ifdef CCR_SAVE_EN
    ccr_t saved_ccr;

    // Restore beats the ALU update and acts through stalls; flush blocks both strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr       <= '0;
            saved_ccr <= '0;
        end else begin
            if (!flush && int_restore) begin
                ccr <= saved_ccr;
            end else begin
                ccr <= ccr_alu_next;
            end
            if (!flush && int_save && !int_restore) begin
                saved_ccr <= ccr;
            end
        end
    end
`else
    // Strobes are kept on the interface but have no effect in this build
    logic unused_int_strobes;
    assign unused_int_strobes = int_save | int_restore;

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr <= '0;
        end else begin
            ccr <= ccr_alu_next;
        end
    end
`endif

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: carries the ALU result, destination and memory
// control one cycle forward, owns the condition-code register and exposes
// a forwarding path from the registered result.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ex_valid, stall, flush           capture control (rst > flush > stall)
//   alu_out, alu_ccr, ccr_we         ALU result, flags, flag update mask
//   setc, clrc                       carry force
//   ex_rd, ex_wb_en, ex_mem_rd,
//   ex_mem_wr, ex_store_data         fields carried forward
//   int_save, int_restore            CCR shadow strobes (CCR_SAVE_EN only)
//   mem_*                            registered stage outputs
//   ccr                              condition-code register
//   fwd_valid, fwd_data              forwarding taps from the stage registers
// Macro: CCR_SAVE_EN enables interrupt save/restore of the CCR.
module ex_mem_stage
    import riscp_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [2:0]         alu_ccr,
    input  logic [2:0]         ccr_we,
    input  logic               setc,
    input  logic               clrc,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_wb_en,
    input  logic               ex_mem_rd,
    input  logic               ex_mem_wr,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic               int_save,
    input  logic               int_restore,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_alu_out,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_wb_en,
    output logic               mem_mem_rd,
    output logic               mem_mem_wr,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [2:0]         ccr,
    output logic               fwd_valid,
    output logic [DATA_W-1:0]  fwd_data
);

    // Pipeline register; flush kills control but leaves data fields in place
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_alu_out    <= '0;
            mem_rd         <= '0;
            mem_wb_en      <= 1'b0;
            mem_mem_rd     <= 1'b0;
            mem_mem_wr     <= 1'b0;
            mem_store_data <= '0;
        end else if (flush) begin
            mem_valid  <= 1'b0;
            mem_wb_en  <= 1'b0;
            mem_mem_rd <= 1'b0;
            mem_mem_wr <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_alu_out    <= alu_out;
            mem_rd         <= ex_rd;
            mem_wb_en      <= ex_wb_en;
            mem_mem_rd     <= ex_mem_rd;
            mem_mem_wr     <= ex_mem_wr;
            mem_store_data <= ex_store_data;
        end
    end

    assign fwd_valid = mem_valid & mem_wb_en;
    assign fwd_data  = mem_alu_out;

    ccr_reg u_ccr_reg (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .stall       (stall),
        .flush       (flush),
        .alu_ccr     (alu_ccr),
        .ccr_we      (ccr_we),
        .setc        (setc),
        .clrc        (clrc),
        .int_save    (int_save),
        .int_restore (int_restore),
        .ccr         (ccr)
    );

endmodule
